multicycle_ctrl: RTL

Control unit that sequences a multicycle ARM datapath. The datapath has a shared instruction/data memory port, IR/Data/ALUOut registers, and register-file read/write logic with R15 = PC+8. The block decodes the latched instruction, runs a Moore FSM over FETCH/DECODE/EXECUTE/MEM/WB steps, holds the NZCV flags register, and gates all architectural write enables by condition evaluation. It is the sequencing counterpart to the existing single-cycle datapath; data-path control encodings are unchanged.

---
 rtl/arm_ctrl_pkg.sv | 53 +++++
 rtl/multicycle_ctrl_if.sv | 33 +++
 rtl/cond_unit.sv | 66 ++++++
 rtl/multicycle_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: shared encodings for the multicycle ARM control unit.
//   statetype     - FSM state encoding
//   OP_*, CMD_*   - instruction field values
//   ALU_*, RES_*, SRCB_* - datapath mux/ALU control encodings
//   cond_t        - ARM condition code list
//   alu_ctrl()    - maps a DP cmd field onto an ALUControl encoding
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } statetype;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_B   = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_t;

    // Unsupported commands fall through to add.
    function automatic logic [1:0] alu_ctrl(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD:          alu_ctrl = ALU_ADD;
            CMD_SUB, CMD_CMP: alu_ctrl = ALU_SUB;
            CMD_AND:          alu_ctrl = ALU_AND;
            CMD_ORR:          alu_ctrl = ALU_ORR;
            default:          alu_ctrl = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction/flag inputs and datapath control outputs
// between the multicycle control unit and its datapath.
//   Instr[19:0]  - IR bits [31:12]
//   ALUFlags     - live NZCV from the ALU
//   remaining    - datapath enables and mux selects
// master: datapath side (drives Instr/ALUFlags); slave: control unit.
interface multicycle_ctrl_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUControl;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;
    logic        RegWrite;

    modport master (
        output Instr, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite
    );

    modport slave (
        input  Instr, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite
    );
endinterface

// File: rtl/cond_unit.sv
// cond_unit: NZCV flags register and condition evaluation.
//   clk, reset   - clock, synchronous active-low reset
//   cond_i       - instruction condition field
//   alu_flags_i  - live NZCV from the ALU
//   flag_w_i     - flag-setting execute step in progress
//   cv_w_i       - ALU op is add/sub, so C and V are meaningful
//   cond_ex_o    - condition passes against the registered flags
module cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic       flag_w_i,
    input  logic       cv_w_i,
    output logic       cond_ex_o
);

    logic [3:0] flags_q, flags_d;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_t'(cond_i))
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = ~z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = ~c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = ~n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = ~v;
            COND_HI: cond_ex_o = c & ~z;
            COND_LS: cond_ex_o = ~c | z;
            COND_GE: cond_ex_o = (n == v);
            COND_LT: cond_ex_o = (n != v);
            COND_GT: cond_ex_o = ~z & (n == v);
            COND_LE: cond_ex_o = z | (n != v);
            COND_AL: cond_ex_o = 1'b1;
            COND_NV: cond_ex_o = 1'b0;
        endcase
    end

    // Logical ops leave C and V untouched.
    always_comb begin
        flags_d = flags_q;
        if (flag_w_i && cond_ex_o) begin
            flags_d[3:2] = alu_flags_i[3:2];
            if (cv_w_i) begin
                flags_d[1:0] = alu_flags_i[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing a multicycle ARM datapath.
//   clk    - system clock, rising edge
//   reset  - synchronous active-low reset
//   bus    - slave side of multicycle_ctrl_if (Instr/ALUFlags in,
//            datapath enables and selects out)
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+4
// DECODE | read registers, route by op
// MEMADR | compute load/store address
// MEMRD  | read data memory
// MEMWB  | write loaded data to Rd
// MEMWR  | write store data to memory
// EXECR  | DP with register operand
// EXECI  | DP with immediate operand
// ALUWB  | write ALU result to Rd
// BRANCH | PC <= PC+8+offset
module multicycle_ctrl
    import arm_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.slave  bus
);

    statetype   state_q, state_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic [3:0] rd;
    logic       is_imm, is_load, is_cmp, s_bit;
    logic [1:0] cmd_alu;
    logic       cond_ex;
    logic       unused_rn;

    logic       pcw, adr_src, memw, irw, src_a, regw;
    logic [1:0] res_src, alu_ctl, src_b;

    assign cond      = bus.Instr[19:16];
    assign op        = bus.Instr[15:14];
    assign funct     = bus.Instr[13:8];
    assign rd        = bus.Instr[3:0];
    assign unused_rn = ^bus.Instr[7:4];

    assign cmd     = funct[4:1];
    assign is_imm  = funct[5];
    assign is_load = funct[0];
    assign is_cmp  = (cmd == CMD_CMP);
    assign s_bit   = funct[0] | is_cmp;
    assign cmd_alu = alu_ctrl(cmd);

    cond_unit u_cond (
        .clk         (clk),
        .reset       (reset),
        .cond_i      (cond),
        .alu_flags_i (bus.ALUFlags),
        .flag_w_i    (((state_q == EXECR) || (state_q == EXECI)) && s_bit && reset),
        .cv_w_i      ((cmd_alu == ALU_ADD) || (cmd_alu == ALU_SUB)),
        .cond_ex_o   (cond_ex)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pcw     = 1'b0;
        adr_src = 1'b0;
        memw    = 1'b0;
        irw     = 1'b0;
        res_src = RES_ALUOUT;
        alu_ctl = ALU_ADD;
        src_a   = 1'b0;
        src_b   = SRCB_RD2;
        regw    = 1'b0;
        case (state_q)
            FETCH: begin
                irw     = 1'b1;
                src_a   = 1'b1;
                src_b   = SRCB_FOUR;
                res_src = RES_ALURESULT;
                pcw     = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                src_a   = 1'b1;
                src_b   = SRCB_FOUR;
                res_src = RES_ALURESULT;
                case (op)
                    OP_MEM: state_d = MEMADR;
                    OP_DP:  state_d = is_imm ? EXECI : EXECR;
                    OP_B:   state_d = BRANCH;
                    OP_UND: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                src_b   = SRCB_EXTIMM;
                state_d = is_load ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr_src = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                res_src = RES_DATA;
                regw    = cond_ex;
                pcw     = cond_ex && (rd == 4'hF);
                state_d = FETCH;
            end
            MEMWR: begin
                adr_src = 1'b1;
                memw    = cond_ex;
                state_d = FETCH;
            end
            EXECR: begin
                alu_ctl = cmd_alu;
                state_d = ALUWB;
            end
            EXECI: begin
                src_b   = SRCB_EXTIMM;
                alu_ctl = cmd_alu;
                state_d = ALUWB;
            end
            ALUWB: begin
                regw    = cond_ex & ~is_cmp;
                pcw     = cond_ex && !is_cmp && (rd == 4'hF);
                state_d = FETCH;
            end
            BRANCH: begin
                src_b   = SRCB_EXTIMM;
                res_src = RES_ALURESULT;
                pcw     = cond_ex;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Architectural writes are suppressed during the reset cycle itself.
    assign bus.PCWrite    = pcw & reset;
    assign bus.MemWrite   = memw & reset;
    assign bus.IRWrite    = irw & reset;
    assign bus.RegWrite   = regw & reset;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = res_src;
    assign bus.ALUControl = alu_ctl;
    assign bus.ALUSrcA    = src_a;
    assign bus.ALUSrcB    = src_b;
    assign bus.ImmSrc     = op;
    assign bus.RegSrc     = {(op == OP_MEM), (op == OP_B)};

endmodule
